button_debounce_reader: RTL and testbench
=========================================

// Module: button_debounce_reader
// PURPOSE
//  Input-side counterpart to the board's LED drivers. Samples one raw pushbutton pin,
//  synchronises and debounces it on a slow tick, and emits clean press, release and
//  long-press pulses plus an 8-bit press counter. The counter can drive LED1..LED8 directly.
// PARAMETERS
//  TICK_DIV        12000  clk cycles per sample tick (1 ms at 12 MHz)
//  DEBOUNCE_TICKS  20     consecutive ticks of a new level required to accept it
//  LONG_TICKS      1000   ticks held in PRESSED before long_pulse fires
//  ACTIVE_LOW      1      1: pin low = pressed; 0: pin high = pressed
// PORTS
//  clk            in   1  system clock
//  rst            in   1  asynchronous, active-high reset
//  btn_in         in   1  raw pushbutton pin, asynchronous to clk
//  btn_level      out  1  debounced level, 1 = pressed
//  press_pulse    out  1  one-clk pulse on an accepted press
//  release_pulse  out  1  one-clk pulse on an accepted release
//  long_pulse     out  1  one-clk pulse, at most once per press
//  press_count    out  8  number of accepted presses, modulo 256
// BEHAVIOUR
//  - Reset: all outputs are 0. The sync flops reset to the released level. The FSM resets to
//    IDLE. The tick, debounce and hold counters reset to 0. Reset is honoured in any state.
//    A press in progress is discarded, and no release_pulse is produced for it.
//  - Input path: ACTIVE_LOW is applied to btn_in, then a 2-FF synchroniser. The result is
//    sync_p, with 1 = pressed.
//  - Tick: a free-running counter from 0 to TICK_DIV-1. tick is high for one clk when the
//    counter wraps to 0. The first tick comes TICK_DIV cycles after reset release.
//  - All FSM and counter updates happen only on tick cycles. Outputs stay registered between
//    ticks.
//  - FSM:
//    - IDLE: on a tick with sync_p=1, go to PRESS_WAIT with deb=1.
//    - PRESS_WAIT, on a tick:
//      - sync_p=0: go back to IDLE and clear deb (a glitch, ignored).
//      - otherwise deb++.
//      - when deb reaches DEBOUNCE_TICKS: go to PRESSED, set btn_level=1, pulse press_pulse,
//        press_count++, clear hold.
//    - PRESSED, on a tick:
//      - sync_p=1: hold++ (saturates at LONG_TICKS). When hold becomes LONG_TICKS,
//        pulse long_pulse.
//      - sync_p=0: go to RELEASE_WAIT with deb=1.
//    - RELEASE_WAIT, on a tick:
//      - sync_p=1: go back to PRESSED and clear deb. hold is kept, so long_pulse is not
//        repeated.
//      - otherwise deb++.
//      - when deb reaches DEBOUNCE_TICKS: go to IDLE, set btn_level=0, pulse release_pulse.
//  - Latency: press_pulse rises at the clk edge of the DEBOUNCE_TICKS-th consecutive pressed
//    tick. Add 2 clk of synchroniser delay from the pin. press_pulse and btn_level change on
//    the same edge.
//  - Widths and wrap:
//    - deb is clog2(DEBOUNCE_TICKS+1) bits.
//    - hold is clog2(LONG_TICKS+1) bits.
//    - press_count wraps from 255 to 0 with no flag.
//  - Pulse ordering:
//    - press_pulse, release_pulse and long_pulse are never high in the same cycle.
//    - long_pulse always comes after press_pulse.
//    - A release accepted before LONG_TICKS produces no long_pulse.
// STRUCTURE
//  - Shared include ui_defs.vh holds the FSM state localparams (IDLE=0, PRESS_WAIT=1,
//    PRESSED=2, RELEASE_WAIT=3) and the default board CLK_HZ/tick constants.
//  - One sub-module, tick_gen: parameter DIV, ports clk, rst, tick. It is reusable by the
//    LED blink logic.
//  - The synchroniser, FSM and counters stay inline.
// TESTING (sim params: TICK_DIV=4, DEBOUNCE_TICKS=3, LONG_TICKS=10, ACTIVE_LOW=1)
//  1. Clean press: drive btn_in=0 steadily -> one press_pulse within 3 ticks (+2 clk);
//     btn_level=1; press_count=1.
//  2. Bounce: toggle btn_in every 5 clk for 40 clk, then hold at 0 -> exactly one
//     press_pulse, which comes 3 stable ticks after the last edge.
//  3. Glitch: btn_in=0 for 2 ticks, then 1 -> no pulses; btn_level stays 0;
//     press_count stays 0.
//  4. Long press: hold for 15 ticks, then release -> press_pulse, then one long_pulse at
//     hold tick 10, then one release_pulse. A release bounce mid-hold gives no second
//     long_pulse.
//  5. Wrap: 256 clean presses -> press_count goes 255 -> 0, with no other side effects.
//  6. Reset mid-press: assert rst while in PRESSED -> all outputs 0 immediately (async), FSM
//     in IDLE, no release_pulse. A still-held button is re-accepted after 3 ticks.

Source files
------------

// File: rtl/button_debounce_reader_pkg.sv
// Shared definitions for the pushbutton reader and related board UI logic.
//   btn_state_t      : debounce FSM states (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT)
//   CLK_HZ, TICK_HZ  : default board clock and sample-tick rates
//   DEFAULT_TICK_DIV : clk cycles per sample tick at the default rates
package button_debounce_reader_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int unsigned CLK_HZ           = 12_000_000;
    localparam int unsigned TICK_HZ          = 1_000;
    localparam int unsigned DEFAULT_TICK_DIV = CLK_HZ / TICK_HZ;

endpackage

// File: rtl/button_debounce_reader_tick_gen.sv
// tick_gen: free-running divider producing a one-clk tick every DIV cycles.
//   clk  in  system clock
//   rst  in  asynchronous, active-high reset
//   tick out registered one-clk pulse when the counter wraps to 0;
//            first pulse DIV cycles after reset release
module tick_gen
    import button_debounce_reader_pkg::*;
#(
    parameter int unsigned DIV = DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            if (cnt == LAST) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/button_debounce_reader.sv
// button_debounce_reader: synchronises and debounces one raw pushbutton pin on a
// slow sample tick and produces clean press / release / long-press pulses plus an
// 8-bit press counter.
//   clk           in   system clock
//   rst           in   asynchronous, active-high reset
//   btn_in        in   raw pushbutton pin, asynchronous to clk
//   btn_level     out  debounced level, 1 = pressed
//   press_pulse   out  one-clk pulse on an accepted press
//   release_pulse out  one-clk pulse on an accepted release
//   long_pulse    out  one-clk pulse after LONG_TICKS held ticks, once per press
//   press_count   out  accepted presses, modulo 256
module button_debounce_reader
    import button_debounce_reader_pkg::*;
#(
    parameter int unsigned TICK_DIV       = DEFAULT_TICK_DIV,
    parameter int unsigned DEBOUNCE_TICKS = 20,
    parameter int unsigned LONG_TICKS     = 1000,
    parameter bit          ACTIVE_LOW     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_TICKS + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_TICKS + 1);
    localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);

    logic tick;
    logic pin_p;
    logic sync_1;
    logic sync_p;

    btn_state_t        state;
    logic [DEB_W-1:0]  deb;
    logic [DEB_W-1:0]  deb_inc;
    logic [HOLD_W-1:0] hold;

    tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Polarity is applied before the synchroniser so both flops reset to "released".
    assign pin_p = btn_in ^ ACTIVE_LOW;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_p <= 1'b0;
        end else begin
            sync_1 <= pin_p;
            sync_p <= sync_1;
        end
    end

    // Entering a wait state counts the current tick as the first one, so the
    // acceptance test is shared between the stable and the waiting states.
    always_comb begin
        deb_inc = deb + 1'b1;
        if (state == IDLE || state == PRESSED) begin
            deb_inc = DEB_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            deb           <= '0;
            hold          <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            press_count   <= '0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE, PRESS_WAIT: begin
                        if (!sync_p) begin
                            state <= IDLE;
                            deb   <= '0;
                        end else if (deb_inc == DEB_MAX) begin
                            state       <= PRESSED;
                            deb         <= '0;
                            hold        <= '0;
                            btn_level   <= 1'b1;
                            press_pulse <= 1'b1;
                            press_count <= press_count + 8'd1;
                        end else begin
                            state <= PRESS_WAIT;
                            deb   <= deb_inc;
                        end
                    end
                    PRESSED, RELEASE_WAIT: begin
                        if (sync_p) begin
                            if (state == RELEASE_WAIT) begin
                                // Bounce back: hold is kept so long_pulse cannot repeat.
                                state <= PRESSED;
                                deb   <= '0;
                            end else if (hold != HOLD_MAX) begin
                                hold <= hold + 1'b1;
                                if (hold == HOLD_LAST) begin
                                    long_pulse <= 1'b1;
                                end
                            end
                        end else if (deb_inc == DEB_MAX) begin
                            state         <= IDLE;
                            deb           <= '0;
                            btn_level     <= 1'b0;
                            release_pulse <= 1'b1;
                        end else begin
                            state <= RELEASE_WAIT;
                            deb   <= deb_inc;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_debounce_reader.sv
// Scoreboard bench for button_debounce_reader. A reference model predicts pulse
// events from the pin history and pushes them into a queue; a monitor pops and
// compares whenever the DUT raises a pulse.
module tb_button_debounce_reader;

    localparam int TICK_DIV = 4;
    localparam int DEB      = 3;
    localparam int LONG     = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_in = 1'b1;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_count;

    typedef enum {EV_PRESS, EV_RELEASE, EV_LONG} ev_t;
    typedef struct {
        ev_t        kind;
        int         cyc;
        logic [7:0] count;
        logic       level;
    } ev_rec_t;

    ev_rec_t sb[$];

    int tests = 0;
    int fails = 0;

    // reference model state
    int         n = 0;
    logic       pin_d1 = 1'b1;
    logic       pin_d2 = 1'b1;
    logic       m_acc = 1'b0;
    int         m_run = 0;
    int         m_hold = 0;
    logic [7:0] m_count = 8'd0;

    button_debounce_reader #(
        .TICK_DIV       (TICK_DIV),
        .DEBOUNCE_TICKS (DEB),
        .LONG_TICKS     (LONG),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    task automatic push_ev(input ev_t k);
        ev_rec_t e;
        e.kind  = k;
        e.cyc   = n;
        e.count = m_count;
        e.level = m_acc;
        sb.push_back(e);
    endtask

    // Model: the pin is seen 2 clk late; a sample is taken every TICK_DIV clk,
    // the first one TICK_DIV clk after reset release, and its result is visible
    // from the following edge. A level is accepted after DEB consecutive samples.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            n = 0; pin_d1 = 1'b1; pin_d2 = 1'b1;
            m_acc = 1'b0; m_run = 0; m_hold = 0; m_count = 8'd0;
            sb.delete();
        end else begin
            n++;
            if (n > 1 && (n - 1) % TICK_DIV == 0) begin
                if (!m_acc) begin
                    if (pin_d2 == 1'b0) begin
                        m_run++;
                        if (m_run == DEB) begin
                            m_acc = 1'b1; m_run = 0; m_hold = 0;
                            m_count = m_count + 8'd1;
                            push_ev(EV_PRESS);
                        end
                    end else begin
                        m_run = 0;
                    end
                end else begin
                    if (pin_d2 == 1'b0) begin
                        if (m_run > 0) m_run = 0;
                        else if (m_hold < LONG) begin
                            m_hold++;
                            if (m_hold == LONG) push_ev(EV_LONG);
                        end
                    end else begin
                        m_run++;
                        if (m_run == DEB) begin
                            m_acc = 1'b0; m_run = 0;
                            push_ev(EV_RELEASE);
                        end
                    end
                end
            end
            pin_d2 = pin_d1;
            pin_d1 = btn_in;
        end
    end

    // Monitor
    initial forever begin
        int np;
        ev_t act;
        ev_rec_t e;
        @(negedge clk);
        if (!rst && n > 0) begin
            while (sb.size() > 0 && sb[0].cyc < n) begin
                tests++; fails++;
                $display("FAIL missed_event: got none at cycle %0d, expected %s at cycle %0d",
                         n, sb[0].kind.name(), sb[0].cyc);
                void'(sb.pop_front());
            end
            np = int'(press_pulse) + int'(release_pulse) + int'(long_pulse);
            if (np > 1) begin
                tests++; fails++;
                $display("FAIL pulse_overlap: got %0d pulses high at cycle %0d, expected at most 1", np, n);
            end
            if (np >= 1) begin
                act = press_pulse ? EV_PRESS : (release_pulse ? EV_RELEASE : EV_LONG);
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: got %s at cycle %0d, expected no pulse", act.name(), n);
                end else begin
                    e = sb.pop_front();
                    if (e.kind != act || e.cyc != n || e.count != press_count || e.level != btn_level) begin
                        fails++;
                        $display("FAIL event: got %s cyc=%0d count=%0d level=%0b, expected %s cyc=%0d count=%0d level=%0b",
                                 act.name(), n, press_count, btn_level, e.kind.name(), e.cyc, e.count, e.level);
                    end
                end
            end
            tests++;
            if (btn_level !== m_acc || press_count !== m_count) begin
                fails++;
                $display("FAIL state: got level=%0b count=%0d at cycle %0d, expected level=%0b count=%0d",
                         btn_level, press_count, n, m_acc, m_count);
            end
        end
    end

    task automatic hold_pin(input logic v, input int clks);
        btn_in = v;
        repeat (clks) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string name);
        tests++;
        if ({btn_level, press_pulse, release_pulse, long_pulse, press_count} !== 12'd0) begin
            fails++;
            $display("FAIL %s: got level=%0b pp=%0b rp=%0b lp=%0b count=%0d, expected all 0",
                     name, btn_level, press_pulse, release_pulse, long_pulse, press_count);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish, expected end of run");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] cnt_before;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst = 1'b0;

        // clean press then release
        hold_pin(1'b1, 10);
        hold_pin(1'b0, 6 * TICK_DIV);
        hold_pin(1'b1, 6 * TICK_DIV);

        // bounce: toggle every 5 clk for 40 clk, then hold pressed
        for (int i = 0; i < 8; i++) hold_pin((i % 2) ? 1'b1 : 1'b0, 5);
        hold_pin(1'b0, 6 * TICK_DIV);
        hold_pin(1'b1, 6 * TICK_DIV);

        // glitch: 2 ticks pressed only
        cnt_before = m_count;
        hold_pin(1'b0, 2 * TICK_DIV);
        hold_pin(1'b1, 6 * TICK_DIV);
        tests++;
        if (press_count !== cnt_before || btn_level !== 1'b0) begin
            fails++;
            $display("FAIL glitch: got count=%0d level=%0b, expected count=%0d level=0",
                     press_count, btn_level, cnt_before);
        end

        // long press, then long press with a short release bounce mid-hold
        hold_pin(1'b0, 15 * TICK_DIV);
        hold_pin(1'b1, 6 * TICK_DIV);
        hold_pin(1'b0, 12 * TICK_DIV);
        hold_pin(1'b1, 6);
        hold_pin(1'b0, 5 * TICK_DIV);
        hold_pin(1'b1, 6 * TICK_DIV);

        // random segments
        for (int i = 0; i < 60; i++) hold_pin(1'(i % 2), $urandom_range(1, 40));
        hold_pin(1'b1, 6 * TICK_DIV);

        // 256 clean presses with random durations: count wraps through 0
        for (int i = 0; i < 256; i++) begin
            hold_pin(1'b0, $urandom_range(14, 30));
            hold_pin(1'b1, $urandom_range(14, 30));
        end
        hold_pin(1'b1, 4 * TICK_DIV);

        // reset while PRESSED
        hold_pin(1'b0, 6 * TICK_DIV);
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        hold_pin(1'b0, 3);
        check_zero("reset_held");
        rst = 1'b0;
        hold_pin(1'b0, 6 * TICK_DIV);
        tests++;
        if (btn_level !== 1'b1 || press_count !== 8'd1) begin
            fails++;
            $display("FAIL reaccept: got level=%0b count=%0d, expected level=1 count=1", btn_level, press_count);
        end
        hold_pin(1'b1, 8 * TICK_DIV);

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending events, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
